fp_div_sequencer: RTL and testbench

//  Upstream control stage for the FPU iterative divider. Accepts an IEEE-754 single A/B operand pair

---
 rtl/fp_div_sequencer_pkg.sv | 26 ++
 rtl/fp_div_sequencer_classify.sv | 30 +++
 rtl/fp_div_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_fp_div_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fp_div_sequencer_pkg.sv
// Shared constants and types for the FPU divide sequencer.
//   - IEEE-754 single field widths, exponent bias and canonical special encodings.
//   - Sequencer FSM state and operand class enumerations.
package fp_div_sequencer_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned EXP_BIAS  = 127;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF   = 32'h7F800000;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } fp_seq_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

endpackage

// File: rtl/fp_div_sequencer_classify.sv
// Combinational operand classifier for IEEE-754 single precision.
// Denormals are reported as zero because the divide path flushes them.
// Ports:
//   i_op  in  32  operand {sign,exp,frac}; sign is irrelevant to the class
//   o_cls out  2  operand class (zero / normal / infinity / NaN)
module fp_div_sequencer_classify
  import fp_div_sequencer_pkg::*;
(
  input  logic [31:0] i_op,
  output fp_class_t   o_cls
);

  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_unused_sign;

  assign w_exp         = i_op[30:23];
  assign w_frac        = i_op[22:0];
  assign w_unused_sign = i_op[31];

  always_comb begin
    o_cls = CLS_NORM;
    if (w_exp == '0) begin
      o_cls = CLS_ZERO;
    end else if (w_exp == '1) begin
      o_cls = (w_frac == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp_div_sequencer.sv
// Upstream control stage for the iterative FPU divider.
// Accepts an A/B operand pair, resolves special operands locally, otherwise launches the
// divider, waits DIV_LATENCY cycles, clamps the exponent and presents the quotient + flags.
// Ports:
//   fp_clk, fp_rst          clock, synchronous active-high reset
//   in_valid/in_ready       operand handshake; in_a dividend, in_b divisor
//   div_a/div_b/div_start   registered operands and one-cycle launch pulse to the divider
//   div_out                 divider result, sampled DIV_LATENCY cycles after div_start
//   out_valid/out_ready     result handshake; out_data quotient
//   flag_*                  exception flags, exclusive per result
module fp_div_sequencer
  import fp_div_sequencer_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = 27,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        fp_clk,
  input  logic        fp_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic [31:0] div_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        flag_invalid,
  output logic        flag_divzero,
  output logic        flag_overflow,
  output logic        flag_underflow
);

  fp_seq_state_t    r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_div_a, r_div_b, r_out_data;
  logic             r_invalid, r_divzero, r_overflow, r_underflow;

  fp_class_t        w_cls_a, w_cls_b;

  fp_div_sequencer_classify u_cls_a (
    .i_op  (in_a),
    .o_cls (w_cls_a)
  );

  fp_div_sequencer_classify u_cls_b (
    .i_op  (in_b),
    .o_cls (w_cls_b)
  );

  // Special-operand resolution, evaluated on the incoming pair in priority order.
  logic        w_special, w_spec_inv, w_spec_dz, w_in_sign;
  logic [31:0] w_spec_data;

  assign w_in_sign = in_a[31] ^ in_b[31];

  always_comb begin
    w_special   = 1'b1;
    w_spec_inv  = 1'b0;
    w_spec_dz   = 1'b0;
    w_spec_data = '0;
    if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN ||
        (w_cls_a == CLS_ZERO && w_cls_b == CLS_ZERO) ||
        (w_cls_a == CLS_INF && w_cls_b == CLS_INF)) begin
      w_spec_data = CANON_NAN;
      w_spec_inv  = 1'b1;
    end else if (w_cls_a == CLS_INF) begin
      w_spec_data = {w_in_sign, POS_INF[30:0]};
    end else if (w_cls_b == CLS_INF) begin
      w_spec_data = {w_in_sign, 31'h0};
    end else if (w_cls_b == CLS_ZERO) begin
      w_spec_data = {w_in_sign, POS_INF[30:0]};
      w_spec_dz   = 1'b1;
    end else if (w_cls_a == CLS_ZERO) begin
      w_spec_data = {w_in_sign, 31'h0};
    end else begin
      w_special   = 1'b0;
    end
  end

  // Exponent clamp on the latched operands. Ten bits hold the full range of
  // a_exp - b_exp + bias - borrow for normal inputs; bit 9 is the sign.
  logic [9:0]  w_exp;
  logic        w_frac_lt, w_ovf, w_unf, w_q_sign;
  logic [31:0] w_clamp_data;
  logic [8:0]  w_unused_div;

  assign w_frac_lt    = (r_div_a[22:0] < r_div_b[22:0]);
  assign w_exp        = {2'b00, r_div_a[30:23]} - {2'b00, r_div_b[30:23]}
                        + 10'(EXP_BIAS) - {9'd0, w_frac_lt};
  assign w_ovf        = !w_exp[9] && (w_exp >= 10'd255);
  assign w_unf        = w_exp[9] || (w_exp == 10'd0);
  assign w_q_sign     = r_div_a[31] ^ r_div_b[31];
  // Divider sign/exponent are ignored; both are recomputed here.
  assign w_unused_div = div_out[31:23];

  always_comb begin
    w_clamp_data = {w_q_sign, w_exp[7:0], div_out[22:0]};
    if (w_ovf) begin
      w_clamp_data = {w_q_sign, POS_INF[30:0]};
    end else if (w_unf) begin
      w_clamp_data = {w_q_sign, 31'h0};
    end
  end

  // FSM state register
  always_ff @(posedge fp_clk) begin
    if (fp_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_d = w_special ? DONE : LAUNCH;
        end
      end
      LAUNCH: begin
        div_start = 1'b1;
        w_state_d = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge fp_clk) begin
    if (fp_rst) begin
      r_cnt       <= '0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_out_data  <= '0;
      r_invalid   <= 1'b0;
      r_divzero   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_div_a     <= in_a;
            r_div_b     <= in_b;
            r_invalid   <= w_special & w_spec_inv;
            r_divzero   <= w_special & w_spec_dz;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (w_special) begin
              r_out_data <= w_spec_data;
            end
          end
        end
        LAUNCH: begin
          r_cnt <= CNT_W'(DIV_LATENCY - 1);
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_out_data  <= w_clamp_data;
            r_overflow  <= w_ovf;
            r_underflow <= !w_ovf && w_unf;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_a          = r_div_a;
  assign div_b          = r_div_b;
  assign out_data       = r_out_data;
  assign flag_invalid   = r_invalid;
  assign flag_divzero   = r_divzero;
  assign flag_overflow  = r_overflow;
  assign flag_underflow = r_underflow;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Directed bench for fp_div_sequencer with a behavioural fixed-latency divider.
module tb_fp_div_sequencer;

  localparam int unsigned LAT = 27;

  logic        fp_clk = 1'b0;
  logic        fp_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] div_a, div_b, div_out;
  logic        div_start;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        flag_invalid, flag_divzero, flag_overflow, flag_underflow;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  fp_div_sequencer #(
    .DIV_LATENCY (LAT),
    .CNT_W       (5)
  ) dut (
    .fp_clk         (fp_clk),
    .fp_rst         (fp_rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .div_a          (div_a),
    .div_b          (div_b),
    .div_start      (div_start),
    .div_out        (div_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .flag_invalid   (flag_invalid),
    .flag_divzero   (flag_divzero),
    .flag_overflow  (flag_overflow),
    .flag_underflow (flag_underflow)
  );

  always #5 fp_clk = ~fp_clk;

  // Behavioural divider: result is valid only in the cycle LAT cycles after div_start,
  // garbage otherwise, so early or late sampling is visible.
  logic [31:0] m_q = '0;
  logic [4:0]  m_cnt = '0;
  logic        m_busy = 1'b0;

  always @(posedge fp_clk) begin
    if (fp_rst) begin
      m_busy <= 1'b0;
    end else if (div_start) begin
      m_busy   <= 1'b1;
      m_cnt    <= 5'(LAT - 1);
      n_starts <= n_starts + 1;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 5'd1;
    end
  end

  assign div_out = (m_busy && m_cnt == 0) ? m_q : 32'hDEADBEEF;

  task automatic tick();
    @(posedge fp_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, flag_invalid, flag_divzero, flag_overflow, flag_underflow};
  endfunction

  // Issue one operation, measure latency to out_valid, check result, then retire it.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] exp_data,
                       input logic [3:0] exp_flags, input int exp_lat, input int exp_starts);
    int lat;
    int s0;
    s0  = n_starts;
    m_q = q;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".div_a"}, div_a, a);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".flags"}, flags(), {28'd0, exp_flags});
    check({tag, ".starts"}, 32'(n_starts - s0), 32'(exp_starts));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".retired"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    fp_rst = 1'b0;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.div_start", 32'(div_start), 32'd0);
    check("rst.out_data",  out_data, 32'h0);
    check("rst.div_a",     div_a,    32'h0);
    check("rst.div_b",     div_b,    32'h0);
    check("rst.flags",     flags(),  32'h0);

    // Ordinary and special operations {invalid,divzero,overflow,underflow}
    do_op("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000, 29, 1);
    do_op("div1_0",   32'h3F800000, 32'h00000000, 32'h0,        32'h7F800000, 4'b0100, 1, 0);
    do_op("z_z",      32'h80000000, 32'h00000000, 32'h0,        32'h7FC00000, 4'b1000, 1, 0);
    do_op("inf_inf",  32'h7F800000, 32'hFF800000, 32'h0,        32'h7FC00000, 4'b1000, 1, 0);
    do_op("nan_b",    32'h3F800000, 32'h7F800001, 32'h0,        32'h7FC00000, 4'b1000, 1, 0);
    do_op("inf_fin",  32'hFF800000, 32'h40000000, 32'h0,        32'hFF800000, 4'b0000, 1, 0);
    do_op("fin_inf",  32'h3F800000, 32'hFF800000, 32'h0,        32'h80000000, 4'b0000, 1, 0);
    do_op("zero_nz",  32'h00000000, 32'hC0000000, 32'h0,        32'h80000000, 4'b0000, 1, 0);
    do_op("denorm",   32'h00000001, 32'h3F800000, 32'h0,        32'h00000000, 4'b0000, 1, 0);
    do_op("ovf",      32'h7F000000, 32'h3E800000, 32'h12345678, 32'h7F800000, 4'b0010, 29, 1);
    do_op("unf",      32'h00800000, 32'h40000000, 32'h00400000, 32'h00000000, 4'b0001, 29, 1);
    do_op("div3_4",   32'h40400000, 32'h40800000, 32'h3F400000, 32'h3F400000, 4'b0000, 29, 1);
    do_op("div1_1p5", 32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 32'h3F2AAAAB, 4'b0000, 29, 1);
    // Divider sign/exponent fields must be ignored
    do_op("neg6_2",   32'hC0C00000, 32'h40000000, 32'h40400000, 32'hC0400000, 4'b0000, 29, 1);

    // Backpressure: hold DONE for 5 cycles while in_valid is offered
    m_q = 32'h40400000;
    in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
    tick();
    in_a = 32'h3F800000; in_b = 32'h00000000;
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.in_ready",  32'(in_ready),  32'd0);
      check("bp.out_data",  out_data, 32'h40400000);
      tick();
    end
    check("bp.div_a_held", div_a, 32'h40C00000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.retired", 32'(in_ready), 32'd1);

    // Reset during WAIT aborts the operation
    in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    fp_rst = 1'b1;
    tick();
    fp_rst = 1'b0;
    check("rmid.out_valid", 32'(out_valid), 32'd0);
    check("rmid.in_ready",  32'(in_ready),  32'd1);
    check("rmid.div_start", 32'(div_start), 32'd0);
    check("rmid.div_a",     div_a, 32'h0);
    do_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000, 29, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
